// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM encoding, field widths, time payload.
package stopwatch_pkg;

    localparam int unsigned MS_W  = 10;
    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 6;

    localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(999);
    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10,
        ST_LAP  = 2'b11
    } sw_state_t;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
        logic [MS_W-1:0]  ms;
    } sw_time_t;

endpackage

// File: rtl/edge_sync.sv
// Synchronizer chain for an asynchronous level, followed by a one-cycle rising-edge pulse.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_pulse_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Pulse is combinational so the consumer registers it in the same cycle.
    assign o_pulse_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch: start/stop/lap/clear FSM, cascaded ms/sec/min counters, lap register and display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_MIN     = 59
) (
    input  logic             Clock_5K,
    input  logic             Reset,
    input  logic             Clock_1MSec,
    input  logic             Btn_StartStop,
    input  logic             Btn_LapClear,
    output logic [MIN_W-1:0] Disp_Min,
    output logic [SEC_W-1:0] Disp_Sec,
    output logic [MS_W-1:0]  Disp_MSec,
    output logic             Running,
    output logic             Lap_Active,
    output logic             Overflow
);

    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MIN);

    logic      w_tick;
    logic      w_ss_p;
    logic      w_lc_p;

    sw_state_t r_state;
    sw_state_t w_state_nxt;
    logic      w_capture;
    logic      w_clear;

    sw_time_t  r_cnt;
    sw_time_t  w_cnt_nxt;
    sw_time_t  r_lap;
    sw_time_t  w_lap_nxt;
    sw_time_t  r_disp;
    sw_time_t  w_disp_nxt;
    logic      w_count_en;
    logic      w_wrap_all;
    logic      r_overflow;
    logic      w_overflow_nxt;
    logic      r_running;
    logic      r_lap_active;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
        .i_clk     (Clock_5K),
        .i_rst_n   (Reset),
        .i_async   (Clock_1MSec),
        .o_pulse_c (w_tick)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .i_clk     (Clock_5K),
        .i_rst_n   (Reset),
        .i_async   (Btn_StartStop),
        .o_pulse_c (w_ss_p)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lc (
        .i_clk     (Clock_5K),
        .i_rst_n   (Reset),
        .i_async   (Btn_LapClear),
        .o_pulse_c (w_lc_p)
    );

    always_ff @(posedge Clock_5K or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Start/stop has priority: a same-cycle lap/clear press is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_p) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_ss_p) begin
                    w_state_nxt = ST_STOP;
                end else if (w_lc_p) begin
                    w_state_nxt = ST_LAP;
                    w_capture   = 1'b1;
                end
            end
            ST_LAP: begin
                if (w_ss_p) begin
                    w_state_nxt = ST_STOP;
                end else if (w_lc_p) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STOP: begin
                if (w_ss_p) begin
                    w_state_nxt = ST_RUN;
                end else if (w_lc_p) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counting is gated by the pre-transition state.
    assign w_count_en = w_tick && ((r_state == ST_RUN) || (r_state == ST_LAP));

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_wrap_all = 1'b0;
        if (w_clear) begin
            w_cnt_nxt = '0;
        end else if (w_count_en) begin
            if (r_cnt.ms != MS_MAX) begin
                w_cnt_nxt.ms = r_cnt.ms + MS_W'(1);
            end else begin
                w_cnt_nxt.ms = '0;
                if (r_cnt.sec != SEC_MAX) begin
                    w_cnt_nxt.sec = r_cnt.sec + SEC_W'(1);
                end else begin
                    w_cnt_nxt.sec = '0;
                    if (r_cnt.min != MIN_LAST) begin
                        w_cnt_nxt.min = r_cnt.min + MIN_W'(1);
                    end else begin
                        w_cnt_nxt.min = '0;
                        w_wrap_all    = 1'b1;
                    end
                end
            end
        end
    end

    // Lap captures the pre-increment live value; display follows the next state.
    always_comb begin
        w_lap_nxt      = r_lap;
        w_overflow_nxt = r_overflow | w_wrap_all;
        if (w_clear) begin
            w_lap_nxt      = '0;
            w_overflow_nxt = 1'b0;
        end else if (w_capture) begin
            w_lap_nxt = r_cnt;
        end
        w_disp_nxt = (w_state_nxt == ST_LAP) ? w_lap_nxt : w_cnt_nxt;
    end

    always_ff @(posedge Clock_5K or negedge Reset) begin
        if (!Reset) begin
            r_cnt        <= '0;
            r_lap        <= '0;
            r_disp       <= '0;
            r_overflow   <= 1'b0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_lap        <= w_lap_nxt;
            r_disp       <= w_disp_nxt;
            r_overflow   <= w_overflow_nxt;
            r_running    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAP);
            r_lap_active <= (w_state_nxt == ST_LAP);
        end
    end

    assign Disp_Min   = r_disp.min;
    assign Disp_Sec   = r_disp.sec;
    assign Disp_MSec  = r_disp.ms;
    assign Running    = r_running;
    assign Lap_Active = r_lap_active;
    assign Overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (MAX_MIN=0) with a 3-high/2-low 1 ms tick model.
module tb_stopwatch_ctrl;

    logic       Clock_5K;
    logic       Reset;
    logic       Clock_1MSec;
    logic       Btn_StartStop;
    logic       Btn_LapClear;
    logic [5:0] Disp_Min;
    logic [5:0] Disp_Sec;
    logic [9:0] Disp_MSec;
    logic       Running;
    logic       Lap_Active;
    logic       Overflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [24:0] obs;
    assign obs = {Disp_Min, Disp_Sec, Disp_MSec, Running, Lap_Active, Overflow};

    stopwatch_ctrl #(.SYNC_STAGES(2), .MAX_MIN(0)) dut (
        .Clock_5K      (Clock_5K),
        .Reset         (Reset),
        .Clock_1MSec   (Clock_1MSec),
        .Btn_StartStop (Btn_StartStop),
        .Btn_LapClear  (Btn_LapClear),
        .Disp_Min      (Disp_Min),
        .Disp_Sec      (Disp_Sec),
        .Disp_MSec     (Disp_MSec),
        .Running       (Running),
        .Lap_Active    (Lap_Active),
        .Overflow      (Overflow)
    );

    initial begin
        Clock_5K = 1'b0;
        forever #5 Clock_5K = ~Clock_5K;
    end

    function automatic logic [24:0] exp_v(input int mn, input int sc, input int ms,
                                          input bit r, input bit l, input bit o);
        return {6'(mn), 6'(sc), 10'(ms), r, l, o};
    endfunction

    function automatic string fmt(input logic [24:0] v);
        return $sformatf("%0d:%0d.%0d run=%b lap=%b ovf=%b",
                         v[24:19], v[18:13], v[12:3], v[2], v[1], v[0]);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock_5K);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            Clock_1MSec = 1'b1;
            cyc(3);
            Clock_1MSec = 1'b0;
            cyc(2);
        end
    endtask

    task automatic press_ss();
        Btn_StartStop = 1'b1;
        cyc(4);
        Btn_StartStop = 1'b0;
        cyc(4);
    endtask

    task automatic press_lc();
        Btn_LapClear = 1'b1;
        cyc(4);
        Btn_LapClear = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset();
        logic [24:0] e;
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        e = exp_v(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL reset_outputs: got %s want %s", fmt(obs), fmt(e));
        end
        cyc(2);
        Reset = 1'b1;
        cyc(4);
    endtask

    task automatic test_count();
        logic [24:0] e;
        press_ss();
        ticks(1000);
        e = exp_v(0, 1, 0, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL count_1000: got %s want %s", fmt(obs), fmt(e));
        end
        press_ss();
        ticks(50);
        e = exp_v(0, 1, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL stop_hold: got %s want %s", fmt(obs), fmt(e));
        end
        press_lc();
    endtask

    task automatic test_lap();
        logic [24:0] e;
        press_ss();
        ticks(250);
        press_lc();
        e = exp_v(0, 0, 250, 1, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL lap_freeze: got %s want %s", fmt(obs), fmt(e));
        end
        ticks(500);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL lap_frozen_500: got %s want %s", fmt(obs), fmt(e));
        end
        press_lc();
        e = exp_v(0, 0, 750, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL lap_release: got %s want %s", fmt(obs), fmt(e));
        end
        press_ss();
        press_lc();
    endtask

    task automatic test_simultaneous();
        logic [24:0] e;
        logic [21:0] lap_e;
        press_ss();
        ticks(10);
        press_lc();
        press_lc();
        ticks(5);
        Btn_StartStop = 1'b1;
        Btn_LapClear  = 1'b1;
        cyc(4);
        Btn_StartStop = 1'b0;
        Btn_LapClear  = 1'b0;
        cyc(4);
        e = exp_v(0, 0, 15, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL both_buttons: got %s want %s", fmt(obs), fmt(e));
        end
        lap_e = {6'd0, 6'd0, 10'd10};
        n_cmp++;
        if (dut.r_lap !== lap_e) begin
            n_bad++;
            $display("FAIL both_lap_kept: got %h want %h", dut.r_lap, lap_e);
        end
        // Tick aligned with Start while running.
        press_ss();
        Clock_1MSec   = 1'b1;
        Btn_StartStop = 1'b1;
        cyc(3);
        Clock_1MSec   = 1'b0;
        cyc(1);
        Btn_StartStop = 1'b0;
        cyc(5);
        e = exp_v(0, 0, 16, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL tick_with_stop: got %s want %s", fmt(obs), fmt(e));
        end
        // Tick aligned with Lap while running.
        press_ss();
        Clock_1MSec  = 1'b1;
        Btn_LapClear = 1'b1;
        cyc(3);
        Clock_1MSec  = 1'b0;
        cyc(1);
        Btn_LapClear = 1'b0;
        cyc(5);
        e = exp_v(0, 0, 16, 1, 1, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL tick_with_lap: got %s want %s", fmt(obs), fmt(e));
        end
        press_lc();
        e = exp_v(0, 0, 17, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL tick_lap_release: got %s want %s", fmt(obs), fmt(e));
        end
        press_ss();
        press_lc();
    endtask

    task automatic test_wrap();
        logic [24:0] e;
        press_ss();
        press_ss();
        // Preload the live counter near the top so the wrap is reached quickly.
        force dut.r_cnt = {6'd0, 6'd59, 10'd990};
        cyc(1);
        release dut.r_cnt;
        cyc(2);
        e = exp_v(0, 59, 990, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL wrap_preload: got %s want %s", fmt(obs), fmt(e));
        end
        press_ss();
        ticks(9);
        e = exp_v(0, 59, 999, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL wrap_top: got %s want %s", fmt(obs), fmt(e));
        end
        ticks(1);
        e = exp_v(0, 0, 0, 1, 0, 1);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL wrap_zero: got %s want %s", fmt(obs), fmt(e));
        end
        ticks(1);
        e = exp_v(0, 0, 1, 1, 0, 1);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL wrap_continue: got %s want %s", fmt(obs), fmt(e));
        end
    endtask

    task automatic test_clear();
        logic [24:0] e;
        ticks(5122);
        press_ss();
        e = exp_v(0, 5, 123, 0, 0, 1);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL clear_pre: got %s want %s", fmt(obs), fmt(e));
        end
        press_lc();
        e = exp_v(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL clear_idle: got %s want %s", fmt(obs), fmt(e));
        end
        press_lc();
        ticks(3);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL idle_lap_ignored: got %s want %s", fmt(obs), fmt(e));
        end
        press_ss();
        ticks(2);
        e = exp_v(0, 0, 2, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL restart_from_zero: got %s want %s", fmt(obs), fmt(e));
        end
    endtask

    task automatic test_async_reset();
        logic [24:0] e;
        ticks(2398);
        e = exp_v(0, 2, 400, 1, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL run_2400: got %s want %s", fmt(obs), fmt(e));
        end
        #2 Reset = 1'b0;
        #1;
        e = exp_v(0, 0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL async_reset: got %s want %s", fmt(obs), fmt(e));
        end
        @(negedge Clock_5K);
        Reset = 1'b1;
        ticks(3);
        cyc(3);
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL no_resume: got %s want %s", fmt(obs), fmt(e));
        end
    endtask

    initial begin
        Reset         = 1'b1;
        Clock_1MSec   = 1'b0;
        Btn_StartStop = 1'b0;
        Btn_LapClear  = 1'b0;
        test_reset();
        test_count();
        test_lap();
        test_simultaneous();
        test_wrap();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch that consumes the 1 ms tick clock produced by the clock generator and turns it into a minutes/seconds/milliseconds count. Everything runs on the 5 kHz system clock; the 1 ms clock input is treated as data. It is synchronized and edge-detected, never used as a clock. Two pre-debounced buttons drive a start/stop/lap/clear state machine. Outputs feed the display driver.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on each asynchronous input (≥2).
- `MAX_MIN`, 59: highest minute value before wrap.
- `Clock_5K` input 1: system clock; all flops on its rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `Clock_1MSec` input 1: 1 ms square wave, one rising edge per ms.
- `Btn_StartStop` input 1: debounced level, active-high.
- `Btn_LapClear` input 1: debounced level, active-high.
- `Disp_Min` output 6: displayed minutes, 0..`MAX_MIN`.
- `Disp_Sec` output 6: displayed seconds, 0..59.
- `Disp_MSec` output 10: displayed milliseconds, 0..999.
- `Running` output 1: high in RUN and LAP.
- `Lap_Active` output 1: high in LAP; display is frozen.
- `Overflow` output 1: sticky; set on wrap past `MAX_MIN`:59.999.

## Operation
**Input conditioning**
- Each of the three inputs passes through `SYNC_STAGES` flops, then a rising-edge detector.
- This yields one-cycle pulses `tick`, `ss_p` and `lc_p`. Level-held buttons produce exactly one pulse.

**States:** IDLE, RUN, STOP, LAP.
- IDLE: `ss_p` → RUN. `lc_p` is ignored.
- RUN: `ss_p` → STOP. `lc_p` → LAP, and the live count is copied into the lap register.
- LAP: `ss_p` → STOP, and the display returns to the live count. `lc_p` → RUN, releasing the freeze.
- STOP: `ss_p` → RUN. `lc_p` → IDLE, clearing the counters, the lap register and `Overflow`.
- `ss_p` and `lc_p` in the same cycle: `ss_p` wins and `lc_p` is discarded.

**Counting**
- Counting happens on `tick` only while the current state is RUN or LAP.
- ms counts 999→0 with a carry into sec. sec counts 59→0 with a carry into min.
- At `MAX_MIN`:59.999 the next tick gives 0:00.000 and sets `Overflow`. Counting continues.
- Cascade: all three fields update in the same cycle.

**Simultaneous tick and button**
- The count step uses the state held before the transition.
- RUN with `tick` and `ss_p`: the count increments and the state becomes STOP.
- RUN with `tick` and `lc_p`: the lap register captures the pre-increment value.

**Display**
- LAP shows the lap register.
- All other states show the live counter.

## Timing
**Reset**
- Async assert: state IDLE; counters, lap register and synchronizer flops go to 0.
- All outputs go to 0: `Disp_*`=0, `Running`=0, `Lap_Active`=0, `Overflow`=0.
- Reset deassertion is taken synchronously. The first pulse can occur no earlier than `SYNC_STAGES`+1 cycles after release.
- Reset mid-count discards all state; there is no resume.

**Latency**
- An input rising edge updates the state, counter and outputs `SYNC_STAGES`+1 cycles later (3 at default).
- Outputs are registered; no combinational path from input to output.

**Tick rate:** nominal 1 tick per 5 `Clock_5K` cycles.

## Structure
**Shared package `stopwatch_pkg`:**
- state encoding: IDLE=2'b00, RUN=2'b01, STOP=2'b10, LAP=2'b11
- constants `MS_MAX`=999 and `SEC_MAX`=59
- field widths 10, 6 and 6

**Sub-module `edge_sync`:** synchronizer chain plus rising-edge pulse, parameterised by `SYNC_STAGES`. Instantiated three times.

The top level contains the FSM, the cascaded BCD-free binary counters, the lap register and the output mux.

## Test plan
Stimulus for all scenarios: `Clock_1MSec` comes from a model that toggles with high for 3 cycles and low for 2 cycles (5-cycle period).

1. **Count from start.** Reset, press Start, allow 1000 ticks → `Disp`=0:01.000 and `Running`=1. Press Start → STOP, and the value holds through 50 more ticks.
2. **Lap freeze and release.** Start, 250 ticks, press Lap → `Disp` frozen at 0:00.250 and `Lap_Active`=1. After 500 more ticks, press Lap → `Disp`=0:00.750 and `Lap_Active`=0.
3. **Wrap.** With `MAX_MIN`=0: Start, 60000 ticks → `Disp`=0:00.000 and `Overflow`=1. After 1 more tick → 0:00.001.
4. **Simultaneous presses.** In RUN, pulse both buttons in the same cycle → STOP, `Lap_Active`=0 and the lap register is unchanged. A tick aligned with Start in RUN is counted.
5. **Clear.** From STOP at 0:05.123 with `Overflow`=1, press Lap → IDLE, `Disp`=0:00.000 and `Overflow`=0. Pressing Lap in IDLE has no effect.
6. **Async reset mid-run.** Assert `Reset` between clock edges while counting at 0:02.400 → all outputs are 0 immediately. After release, 3 ticks with no button press leave `Disp`=0.
